// File: rtl/md_issue_ctrl.sv
// -----------------------------------------------------------------------------
// md_issue_ctrl
//
// Issue controller that sits between the D stage and the HI/LO multiply-divide
// unit. It launches MULT/MULTU/DIV/DIVU/MTHI/MTLO ops into the unit with a
// registered one-cycle start pulse. It stalls any further MD op, including
// HI/LO reads, until the unit is free again. It also keeps a saturating count
// of stalled cycles.
//
// Ports
//   clk        in   1   clock, rising edge
//   reset      in   1   asynchronous reset, active low
//   flush      in   1   kills the D-stage op presented this cycle
//   d_valid    in   1   D-stage instruction valid
//   d_op       in   3   op code (000 NONE, 001 MULT, 011 MULTU, 101 DIV,
//                       111 DIVU, 010 MTHI, 100 MTLO, 110 = NONE)
//   d_from     in   2   read request (01 HI, 10 LO, 00/11 none)
//   d_srcA     in  32   first operand / MTHI-MTLO data
//   d_srcB     in  32   second operand
//   md_busy    in   1   busy flag from the unit
//   stall      out  1   holds the D stage (combinational)
//   md_start   out  3   registered start code, non-zero only in LAUNCH
//   md_srcA    out 32   registered first operand
//   md_srcB    out 32   registered second operand
//   md_from    out  2   combinational read select to the unit
//   stall_cnt  out 16   saturating count of stalled cycles
// -----------------------------------------------------------------------------
module md_issue_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        d_valid,
  input  logic [2:0]  d_op,
  input  logic [1:0]  d_from,
  input  logic [31:0] d_srcA,
  input  logic [31:0] d_srcB,
  input  logic        md_busy,
  output logic        stall,
  output logic [2:0]  md_start,
  output logic [31:0] md_srcA,
  output logic [31:0] md_srcB,
  output logic [1:0]  md_from,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    BUSY   = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [2:0]  md_start_reg;
  logic [31:0] md_srca_reg;
  logic [31:0] md_srcb_reg;
  logic [15:0] stall_cnt_reg;

  // Code 110 and read select 11 are reserved and behave as "nothing".
  logic [2:0] op_code;
  logic [1:0] from_code;
  logic       is_md;
  logic       md_req;
  logic       accept;
  logic       launch;

  assign op_code   = (d_op == 3'b110) ? 3'b000 : d_op;
  assign from_code = (d_from == 2'b11) ? 2'b00 : d_from;
  assign is_md     = (op_code != 3'b000) || (from_code != 2'b00);
  assign md_req    = d_valid && is_md && !flush;

  assign stall  = md_req && (state_reg != IDLE);
  assign accept = md_req && !stall;
  // A write op takes priority over a read request in the same instruction.
  assign launch = accept && (op_code != 3'b000);

  // Reads are only ever accepted in IDLE, so HI/LO are already final.
  assign md_from = (accept && (op_code == 3'b000)) ? from_code : 2'b00;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (launch) state_next = LAUNCH;
      // md_start_reg still holds the launched code during LAUNCH; bit 0
      // marks the arithmetic ops that occupy the unit for several cycles.
      LAUNCH:  state_next = md_start_reg[0] ? BUSY : IDLE;
      BUSY:    if (!md_busy) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      md_start_reg  <= 3'b000;
      md_srca_reg   <= 32'd0;
      md_srcb_reg   <= 32'd0;
      stall_cnt_reg <= 16'd0;
    end else begin
      state_reg    <= state_next;
      // Start code is a single-cycle pulse; operands persist until the next launch.
      md_start_reg <= launch ? op_code : 3'b000;
      if (launch) begin
        md_srca_reg <= d_srcA;
        md_srcb_reg <= d_srcB;
      end
      if (stall && (stall_cnt_reg != 16'hFFFF)) begin
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
      end
    end
  end

  assign md_start  = md_start_reg;
  assign md_srcA   = md_srca_reg;
  assign md_srcB   = md_srcb_reg;
  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_md_issue_ctrl
//
// Directed scenarios plus randomized traffic for md_issue_ctrl, compared every
// cycle against a transaction-level model of the unit's occupancy.
// -----------------------------------------------------------------------------
module tb_md_issue_ctrl;

  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b011;
  localparam logic [2:0] OP_DIV   = 3'b101;
  localparam logic [2:0] OP_DIVU  = 3'b111;
  localparam logic [2:0] OP_MTHI  = 3'b010;
  localparam logic [2:0] OP_MTLO  = 3'b100;
  localparam logic [1:0] RD_HI    = 2'b01;
  localparam logic [1:0] RD_LO    = 2'b10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        d_valid = 1'b0;
  logic [2:0]  d_op = 3'b000;
  logic [1:0]  d_from = 2'b00;
  logic [31:0] d_srcA = 32'd0;
  logic [31:0] d_srcB = 32'd0;
  logic        md_busy = 1'b0;
  logic        stall;
  logic [2:0]  md_start;
  logic [31:0] md_srcA;
  logic [31:0] md_srcB;
  logic [1:0]  md_from;
  logic [15:0] stall_cnt;

  int n_total = 0;
  int n_pass  = 0;

  // Model: the unit is either free, receiving its start pulse this cycle,
  // or working on an arithmetic op until md_busy is seen low.
  int          m_phase = 0;  // 0 free, 1 start pulse, 2 working
  logic [2:0]  m_code  = 3'b000;
  logic [31:0] m_a     = 32'd0;
  logic [31:0] m_b     = 32'd0;
  int          m_cnt   = 0;

  md_issue_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .d_valid   (d_valid),
    .d_op      (d_op),
    .d_from    (d_from),
    .d_srcA    (d_srcA),
    .d_srcB    (d_srcB),
    .md_busy   (md_busy),
    .stall     (stall),
    .md_start  (md_start),
    .md_srcA   (md_srcA),
    .md_srcB   (md_srcB),
    .md_from   (md_from),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_code  = 3'b000;
    m_a     = 32'd0;
    m_b     = 32'd0;
    m_cnt   = 0;
  endtask

  // Checks the current cycle's outputs, then advances the model across the edge.
  task automatic compare_and_advance();
    logic [2:0] op;
    logic [1:0] fr;
    bit         req, exp_stall, acc;
    logic [1:0] exp_from;
    op = (d_op == 3'b110) ? 3'b000 : d_op;
    fr = (d_from == 2'b11) ? 2'b00 : d_from;
    req = d_valid && ((op != 3'b000) || (fr != 2'b00)) && !flush;
    exp_stall = req && (m_phase != 0);
    acc = req && !exp_stall;
    exp_from = (acc && op == 3'b000) ? fr : 2'b00;

    chk("stall", {31'd0, stall}, {31'd0, exp_stall});
    chk("md_from", {30'd0, md_from}, {30'd0, exp_from});
    chk("md_start", {29'd0, md_start}, (m_phase == 1) ? {29'd0, m_code} : 32'd0);
    chk("md_srcA", md_srcA, m_a);
    chk("md_srcB", md_srcB, m_b);
    chk("stall_cnt", {16'd0, stall_cnt}, m_cnt);
    $display("cyc t=%0t v=%0b op=%03b from=%02b fl=%0b busy=%0b | stall=%0b start=%03b from=%02b cnt=%0d",
             $time, d_valid, d_op, d_from, flush, md_busy, stall, md_start, md_from, stall_cnt);

    if (exp_stall && m_cnt < 65535) m_cnt++;
    if (acc && op != 3'b000) begin
      m_phase = 1;
      m_code  = op;
      m_a     = d_srcA;
      m_b     = d_srcB;
    end else if (m_phase == 1) begin
      m_phase = (m_code == OP_MULT || m_code == OP_MULTU ||
                 m_code == OP_DIV  || m_code == OP_DIVU) ? 2 : 0;
    end else if (m_phase == 2 && !md_busy) begin
      m_phase = 0;
    end
  endtask

  task automatic step(input logic v, input logic [2:0] op, input logic [1:0] fr,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic busy, input logic fl);
    @(posedge clk);
    #2;
    d_valid = v; d_op = op; d_from = fr; d_srcA = a; d_srcB = b;
    md_busy = busy; flush = fl;
    #4;
    compare_and_advance();
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3;
    d_valid = 1'b1; d_op = OP_MULT; d_from = 2'b00; flush = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_md_from", {30'd0, md_from}, 32'd0);
    chk("rst_md_start", {29'd0, md_start}, 32'd0);
    chk("rst_md_srcA", md_srcA, 32'd0);
    chk("rst_md_srcB", md_srcB, 32'd0);
    chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    model_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    d_valid = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b0;
    #2;
    chk("init_md_start", {29'd0, md_start}, 32'd0);
    chk("init_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("init_stall", {31'd0, stall}, 32'd0);
    model_reset();
    #4 reset = 1'b1;

    // MULT 3*5, busy six cycles with MFLO waiting, then MFLO completes.
    step(1, OP_MULT, 2'b00, 32'd3, 32'd5, 0, 0);
    chk("mult_accept_stall", {31'd0, stall}, 32'd0);
    step(1, OP_NONE, RD_LO, 32'd0, 32'd0, 1, 0);
    chk("mult_start", {29'd0, md_start}, 32'd1);
    chk("mult_srcA", md_srcA, 32'd3);
    chk("mult_srcB", md_srcB, 32'd5);
    chk("mflo_stall_launch", {31'd0, stall}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      step(1, OP_NONE, RD_LO, 32'd0, 32'd0, 1, 0);
      chk("mflo_stall_busy", {31'd0, stall}, 32'd1);
      chk("mult_start_gone", {29'd0, md_start}, 32'd0);
    end
    step(1, OP_NONE, RD_LO, 32'd0, 32'd0, 0, 0);
    chk("mflo_stall_last", {31'd0, stall}, 32'd1);
    step(1, OP_NONE, RD_LO, 32'd0, 32'd0, 0, 0);
    chk("mflo_released", {31'd0, stall}, 32'd0);
    chk("mflo_from", {30'd0, md_from}, 32'd2);
    chk("cnt_after_mult", {16'd0, stall_cnt}, 32'd8);

    // MTLO then MFLO: exactly one stall cycle, never busy.
    step(1, OP_MTLO, 2'b00, 32'h1234, 32'd0, 1, 0);
    step(1, OP_NONE, RD_LO, 32'd0, 32'd0, 1, 0);
    chk("mtlo_start", {29'd0, md_start}, 32'd4);
    chk("mtlo_srcA", md_srcA, 32'h1234);
    chk("mtlo_mflo_stall", {31'd0, stall}, 32'd1);
    step(1, OP_NONE, RD_LO, 32'd0, 32'd0, 1, 0);
    chk("mtlo_mflo_go", {31'd0, stall}, 32'd0);
    chk("mtlo_mflo_from", {30'd0, md_from}, 32'd2);

    // DIVU busy, MTHI held until the unit frees up.
    step(1, OP_DIVU, 2'b00, 32'd100, 32'd7, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, OP_MTHI, 2'b00, 32'hABCD, 32'd0, 1, 0);
      chk("mthi_stall", {31'd0, stall}, 32'd1);
    end
    step(1, OP_MTHI, 2'b00, 32'hABCD, 32'd0, 0, 0);
    chk("mthi_stall_last", {31'd0, stall}, 32'd1);
    step(1, OP_MTHI, 2'b00, 32'hABCD, 32'd0, 0, 0);
    chk("mthi_accept", {31'd0, stall}, 32'd0);
    step(0, OP_NONE, 2'b00, 32'd0, 32'd0, 0, 0);
    chk("mthi_start", {29'd0, md_start}, 32'd2);

    // Flushed MULT in IDLE is ignored.
    step(1, OP_MULT, 2'b00, 32'd9, 32'd9, 0, 1);
    chk("flush_stall", {31'd0, stall}, 32'd0);
    step(0, OP_NONE, 2'b00, 32'd0, 32'd0, 0, 0);
    chk("flush_start", {29'd0, md_start}, 32'd0);
    chk("flush_srcA_kept", md_srcA, 32'hABCD);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      logic [2:0] rop;
      rop = (($urandom_range(0, 3)) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
      step(1'($urandom_range(0, 3) != 0), rop, 2'($urandom_range(0, 3)),
           $urandom, $urandom, 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 7) == 0));
    end

    // Reset mid-BUSY, then a DIV launches straight after release.
    step(1, OP_DIVU, 2'b00, 32'd1, 32'd2, 0, 0);
    step(0, OP_NONE, 2'b00, 32'd0, 32'd0, 1, 0);
    step(1, OP_NONE, RD_HI, 32'd0, 32'd0, 1, 0);
    async_reset();
    step(1, OP_DIV, 2'b00, 32'd77, 32'd11, 1, 0);
    chk("post_rst_div_stall", {31'd0, stall}, 32'd0);
    step(0, OP_NONE, 2'b00, 32'd0, 32'd0, 1, 0);
    chk("post_rst_div_start", {29'd0, md_start}, 32'd5);
    chk("post_rst_div_srcA", md_srcA, 32'd77);

    // Long BUSY with MFHI waiting drives the counter into saturation.
    for (int i = 0; i < 65540; i++) begin
      step(1, OP_NONE, RD_HI, 32'd0, 32'd0, 1, 0);
    end
    chk("sat_cnt", {16'd0, stall_cnt}, 32'h0000FFFF);
    chk("sat_still_stalling", {31'd0, stall}, 32'd1);
    step(1, OP_NONE, RD_HI, 32'd0, 32'd0, 0, 0);
    step(1, OP_NONE, RD_HI, 32'd0, 32'd0, 0, 0);
    chk("sat_no_wrap", {16'd0, stall_cnt}, 32'h0000FFFF);
    chk("sat_mfhi_from", {30'd0, md_from}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/md_issue_ctrl.md
MD_ISSUE_CTRL -- requirements
Module: md_issue_ctrl

Interface
REQ-001 Port clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 Port reset, input, 1: asynchronous, active-low reset; 0 = reset asserted.
REQ-003 Port flush, input, 1: kills the D-stage op presented this cycle.
REQ-004 Port d_valid, input, 1: D-stage instruction valid.
REQ-005 Port d_op, input, 3: requested op: 000 NONE, 001 MULT, 011 MULTU, 101 DIV, 111 DIVU, 010 MTHI, 100 MTLO; 110 is treated as NONE.
REQ-006 Port d_from, input, 2: read request: 00 none, 01 HI, 10 LO; 11 is treated as none.
REQ-007 Port d_srcA, input, 32: first operand, also MTHI/MTLO data.
REQ-008 Port d_srcB, input, 32: second operand.
REQ-009 Port md_busy, input, 1: busy flag from the HI/LO multiply-divide unit.
REQ-010 Port stall, output, 1: holds the D stage (combinational).
REQ-011 Port md_start, output, 3: registered start code to the unit, same encoding as d_op.
REQ-012 Port md_srcA, output, 32: registered first operand to the unit.
REQ-013 Port md_srcB, output, 32: registered second operand to the unit.
REQ-014 Port md_from, output, 2: combinational read select to the unit.
REQ-015 Port stall_cnt, output, 16: saturating count of stalled cycles.

Function
REQ-016 The block SHALL classify an op as an MD op when d_op is non-NONE or d_from is 01/10.
- If both d_op and d_from are non-zero, d_op wins and d_from is ignored.
REQ-017 The block SHALL implement states IDLE, LAUNCH and BUSY.
REQ-018 stall SHALL equal d_valid & MD-op & ~flush & (state != IDLE).
REQ-019 accept SHALL equal d_valid & MD-op & ~flush & ~stall.
REQ-020 On accept with a non-NONE d_op, the block SHALL perform the following at the next edge:
- latch d_op, d_srcA and d_srcB into md_start, md_srcA and md_srcB;
- enter LAUNCH.
REQ-021 md_start SHALL be non-zero for exactly one cycle (the LAUNCH cycle) and 000 otherwise.
- md_srcA and md_srcB hold their values until the next launch.
REQ-022 LAUNCH SHALL always last one cycle and then transition as follows:
- arithmetic op (code bit0 = 1): go to BUSY;
- MTHI/MTLO: go to IDLE.
REQ-023 BUSY SHALL go to IDLE in the cycle after md_busy is sampled 0; it SHALL remain in BUSY while md_busy = 1.
REQ-024 md_from SHALL be driven as follows:
- equal to d_from when accept is true and d_op = NONE;
- 00 otherwise.
- A read accepted in IDLE therefore sees final HI/LO values.
REQ-025 Any MD op, including reads, presented in LAUNCH or BUSY SHALL stall.
REQ-026 flush SHALL NOT abort a launched op; LAUNCH and BUSY complete normally.
REQ-027 stall_cnt SHALL increment on every cycle with stall = 1 and saturate at 16'hFFFF.
REQ-028 Non-MD instructions (d_valid with NONE and no read) SHALL never stall.

Reset
REQ-029 While reset = 0, the block SHALL force the following regardless of clk:
- state = IDLE;
- md_start = 000, md_srcA = 0, md_srcB = 0;
- stall_cnt = 0.
REQ-030 Because state is IDLE during reset, stall SHALL be 0 and md_from SHALL be 00 during reset.
REQ-031 Reset asserted in LAUNCH or BUSY SHALL abandon tracking, and after release the block SHALL accept a new op immediately.

Verification
REQ-032 MULT with srcA = 3, srcB = 5 in IDLE; md_busy driven high for 6 cycles after LAUNCH, then MFLO presented -> md_start = 001 for 1 cycle with md_srcA = 3, md_srcB = 5; MFLO stalls until md_busy falls, then md_from = 10 in the first IDLE cycle.
REQ-033 MTLO with srcA = 0x1234, followed by MFLO on the next cycle -> stall = 1 for exactly 1 cycle, then md_from = 10; state never enters BUSY.
REQ-034 DIVU in progress (BUSY) and MTHI presented -> stall held for every md_busy = 1 cycle; MTHI launched with md_start = 010 one cycle after return to IDLE.
REQ-035 MULT presented with flush = 1 in IDLE -> stall = 0, md_start stays 000, state stays IDLE.
REQ-036 reset driven low mid-BUSY, between clock edges -> state = IDLE, md_start = 000, stall_cnt = 0 without waiting for clk; a DIV presented after release launches on the next edge.
REQ-037 stall_cnt preloaded near saturation by a long BUSY with MFHI waiting -> count stops at 0xFFFF and does not wrap.
